// File: rtl/memory.sv
// 16K x 32 word RAM with a memory-mapped keyboard register (KBD) at index 3FFF.
// Reads are combinational; RAM writes, KBD acknowledge and key capture act on the clk rising edge.
module memory (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        MemWrite,
  input  logic [31:0] WD,
  input  logic        sample,
  input  logic [7:0]  key_reg,
  output logic [31:0] RD
);

  localparam logic [13:0] KBD_IDX = 14'h3FFF;

  logic [31:0] r_mem [0:16383];

  logic        r_sync1;
  logic        r_sync2;
  logic        r_hist;
  logic        r_valid;
  logic        r_overrun;
  logic [7:0]  r_key;

  logic [13:0] w_idx;
  logic        w_is_kbd;
  logic        w_ram_wr;
  logic        w_kbd_wr;
  logic        w_capture;
  logic        w_unused_addr;

  assign w_idx         = addr[13:0];
  assign w_unused_addr = ^addr[31:14];
  assign w_is_kbd      = (w_idx == KBD_IDX);
  assign w_ram_wr      = MemWrite & ~reset & ~w_is_kbd;
  assign w_kbd_wr      = MemWrite & w_is_kbd;
  assign w_capture     = r_sync2 & ~r_hist;

  // RAM has no reset; it is only written while reset is low.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_mem[w_idx] <= WD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= sample;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // A capture on the same edge as an acknowledge wins, but the acknowledge still clears overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key     <= 8'h00;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_capture) begin
      r_key     <= key_reg;
      r_valid   <= 1'b1;
      r_overrun <= r_valid & ~w_kbd_wr;
    end else if (w_kbd_wr) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign RD = w_is_kbd ? {r_valid, r_overrun, 22'b0, r_key} : r_mem[w_idx];

endmodule

// File: tb/tb_memory.sv
// Bench for memory: table-driven write/read vectors plus hand-written keyboard and reset sequences.
// Expected RD values are pushed to a scoreboard queue when stimulus is driven and popped at each check.
module tb_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        MemWrite;
  logic [31:0] WD;
  logic        sample;
  logic [7:0]  key_reg;
  logic [31:0] RD;

  always #5 clk = ~clk;

  memory dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .MemWrite (MemWrite),
    .WD       (WD),
    .sample   (sample),
    .key_reg  (key_reg),
    .RD       (RD)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wd;
    logic [31:0] raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic expect_rd(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name);
    logic [31:0] e;
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, RD=%h", name, RD);
    end else begin
      e = exp_q.pop_front();
      if (RD !== e) begin
        n_fail++;
        $display("FAIL %s: RD=%h expected %h", name, RD, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [31:0] a, input logic [31:0] e, input string name);
    addr = a;
    expect_rd(e);
    check(name);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_1234, 32'hA5A5_A5A5, 32'h0000_1234, 32'hA5A5_A5A5, "wr_1234"};
    vecs[1]  = '{1'b1, 32'h0000_123C, 32'hA5A5_A596, 32'h0000_123C, 32'hA5A5_A596, "wr_123c"};
    vecs[2]  = '{1'b0, 32'h0000_1234, 32'hA5A5_A5A5, 32'h0000_1234, 32'hA5A5_A5A5, "keep_1234"};
    vecs[3]  = '{1'b0, 32'h0000_123C, 32'hFFFF_FFFF, 32'h0000_123C, 32'hA5A5_A596, "nowr_123c"};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, "wr_0"};
    vecs[5]  = '{1'b1, 32'h0000_3FFE, 32'h1234_5678, 32'h0000_3FFE, 32'h1234_5678, "wr_3ffe"};
    vecs[6]  = '{1'b1, 32'hFFFF_C005, 32'hCAFE_BABE, 32'h0000_0005, 32'hCAFE_BABE, "alias_wr_5"};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8000_1234, 32'hA5A5_A5A5, "alias_rd_1234"};
    vecs[8]  = '{1'b1, 32'h0000_3FFF, 32'hFFFF_FFFF, 32'h0000_3FFF, 32'h0000_0000, "kbd_wr_idle"};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_3FFE, 32'h1234_5678, "kbd_wr_no_ram"};
    vecs[10] = '{1'b1, 32'h0000_2000, 32'h1111_1111, 32'h0000_2000, 32'h1111_1111, "wr_2000"};

    reset = 1'b1; addr = 32'h0000_3FFF; MemWrite = 1'b0; WD = '0; sample = 1'b0; key_reg = '0;
    expect_rd(32'h0);
    check("reset_kbd");
    tick(); tick();
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      addr = vecs[i].waddr; WD = vecs[i].wd; MemWrite = vecs[i].we;
      expect_rd(vecs[i].exp);
      tick();
      MemWrite = 1'b0;
      addr = vecs[i].raddr;
      check(vecs[i].name);
    end

    // Disabled write held over several edges with WD changing
    addr = 32'h0000_123C;
    for (int k = 0; k < 4; k++) begin
      WD = 32'h0F0F_0000 + k;
      tick();
    end
    expect_rd(32'hA5A5_A596);
    check("nowr_multi");

    // Read-during-write: old value before the edge, new value after
    addr = 32'h0000_2000; WD = 32'h0BAD_F00D; MemWrite = 1'b1;
    expect_rd(32'h1111_1111);
    check("rdw_old");
    tick();
    MemWrite = 1'b0;
    expect_rd(32'h0BAD_F00D);
    check("rdw_new");

    // First capture lands on the 3rd edge after the rise
    addr = 32'h0000_3FFF; key_reg = 8'h32; sample = 1'b1;
    tick(); expect_rd(32'h0); check("cap_edge1");
    tick(); expect_rd(32'h0); check("cap_edge2");
    tick(); expect_rd(32'h8000_0032); check("cap_edge3");
    for (int k = 0; k < 4; k++) tick();
    expect_rd(32'h8000_0032); check("level_no_cap");
    sample = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    expect_rd(32'h8000_0032); check("fall_no_cap");

    key_reg = 8'h33; sample = 1'b1;
    tick(); tick();
    expect_rd(32'h8000_0032); check("ovr_edge2");
    tick();
    expect_rd(32'hC000_0033); check("overrun");

    // Acknowledge clears valid/overrun and keeps the key
    MemWrite = 1'b1; WD = 32'hDEAD_BEEF;
    tick();
    MemWrite = 1'b0;
    expect_rd(32'h0000_0033); check("ack");
    read_chk(32'h0000_1234, 32'hA5A5_A5A5, "ack_ram_intact");
    addr = 32'h0000_3FFF;

    // Capture with valid=1, then capture coinciding with an acknowledge
    sample = 1'b0; tick(); tick(); tick();
    key_reg = 8'h40; sample = 1'b1;
    tick(); tick(); tick();
    expect_rd(32'h8000_0040); check("cap_40");
    sample = 1'b0; tick(); tick(); tick();
    key_reg = 8'h44; sample = 1'b1;
    tick(); tick();
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    expect_rd(32'h8000_0044); check("cap_beats_ack");

    // Asynchronous reset mid-operation, with writes blocked and sample already high
    #2;
    reset = 1'b1;
    expect_rd(32'h0); check("async_reset");
    key_reg = 8'h55;
    addr = 32'h0000_1234; WD = 32'h0000_0000; MemWrite = 1'b1;
    tick(); tick();
    MemWrite = 1'b0;
    reset = 1'b0;
    expect_rd(32'hA5A5_A5A5); check("reset_wr_blocked");
    addr = 32'h0000_3FFF;
    tick(); tick();
    expect_rd(32'h0); check("rel_edge2");
    tick();
    expect_rd(32'h8000_0055); check("rel_capture");
    for (int k = 0; k < 4; k++) tick();
    expect_rd(32'h8000_0055); check("rel_once");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
